uart_rx_fifo: RTL

- Receive buffer between the uart core's receive side (dout, rx_done, error) and REG_INTERFACE.
- Captures each received byte together with its error flag into a first-word-fall-through FIFO.
- Exposes level, threshold and idle-timeout indications for the interrupt path (intrif status bits).
- Absorbs software read latency so back-to-back UART frames are not lost.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_fifo_if.sv | 28 ++
 rtl/uart_rx_fifo_mem.sv | 14 +
 rtl/uart_rx_fifo.sv | 67 ++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared uart constants, rx entry type and status bit positions
package uart_pkg;
  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_AW = 4;
  typedef struct packed {
    logic err;
    logic [7:0] data;
  } rx_entry_t;
  localparam int ST_THR_HIT = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_OVERRUN = 2;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receive-side, read-side, config and status signals of the rx fifo
interface uart_rx_fifo_if #(parameter int DW = 8, parameter int AW = 4, parameter int TO_W = 16);
  logic rx_done;
  logic [DW-1:0] rx_dout;
  logic rx_error;
  logic rd_pop;
  logic flush;
  logic clr_status;
  logic [AW:0] thr;
  logic [TO_W-1:0] to_cycles;
  logic [DW-1:0] rd_data;
  logic rd_err;
  logic empty;
  logic full;
  logic [AW:0] level;
  logic thr_hit;
  logic timeout;
  logic overrun;
  logic underflow;
  modport master (
    output rx_done, rx_dout, rx_error, rd_pop, flush, clr_status, thr, to_cycles,
    input rd_data, rd_err, empty, full, level, thr_hit, timeout, overrun, underflow
  );
  modport slave (
    input rx_done, rx_dout, rx_error, rd_pop, flush, clr_status, thr, to_cycles,
    output rd_data, rd_err, empty, full, level, thr_hit, timeout, overrun, underflow
  );
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: DEPTH x (DW+1) storage with one write port and a combinational read port
module uart_rx_fifo_mem #(parameter int DEPTH = 16, parameter int AW = 4, parameter int DW = 8) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [DW:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW:0] rdata
);
  logic [DW:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer with level, threshold, idle-timeout and sticky error flags
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int AW = RX_FIFO_AW,
  parameter int DW = 8,
  parameter int TO_W = 16
) (
  input logic PCLK,
  input logic PRESETn,
  uart_rx_fifo_if.slave bus
);
  logic [AW:0] wr_ptr, rd_ptr, wr_n, rd_n, lvl_n;
  logic [TO_W-1:0] cnt, cnt_n;
  logic [DW:0] head;
  logic rx_q, push_req, do_push, do_pop, empty, full;
  logic thr_hit, timeout, ovr, udf;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign push_req = bus.rx_done & ~rx_q;
  assign do_pop = bus.rd_pop & ~empty;
  // a pop frees the slot, so a full fifo still accepts a same-cycle push
  assign do_push = push_req & (~full | do_pop);
  always_comb begin
    wr_n = bus.flush ? '0 : wr_ptr + (AW+1)'(do_push);
    rd_n = bus.flush ? '0 : rd_ptr + (AW+1)'(do_pop);
    lvl_n = wr_n - rd_n;
    cnt_n = (bus.flush | do_push | do_pop | empty) ? '0 :
            (cnt >= bus.to_cycles ? bus.to_cycles : cnt + 1'b1);
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rx_q <= 1'b0;
      cnt <= '0;
      thr_hit <= 1'b0;
      timeout <= 1'b0;
      ovr <= 1'b0;
      udf <= 1'b0;
    end else begin
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      rx_q <= bus.rx_done;
      cnt <= cnt_n;
      thr_hit <= bus.thr != '0 && lvl_n >= bus.thr;
      timeout <= bus.to_cycles != '0 && cnt_n == bus.to_cycles && lvl_n != '0;
      ovr <= (push_req & full & ~do_pop) | (ovr & ~bus.clr_status);
      udf <= (bus.rd_pop & empty) | (udf & ~bus.clr_status);
    end
  uart_rx_fifo_mem #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_mem (
    .clk(PCLK),
    .we(do_push & ~bus.flush),
    .waddr(wr_ptr[AW-1:0]),
    .wdata({bus.rx_error, bus.rx_dout}),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(head)
  );
  assign bus.rd_data = empty ? '0 : head[DW-1:0];
  assign bus.rd_err = empty ? 1'b0 : head[DW];
  assign bus.empty = empty;
  assign bus.full = full;
  assign bus.level = wr_ptr - rd_ptr;
  assign bus.thr_hit = thr_hit;
  assign bus.timeout = timeout;
  assign bus.overrun = ovr;
  assign bus.underflow = udf;
endmodule
